// File: rtl/ctrl_dispatch_nch.sv
// N-channel control core: routes decoded instructions into per-channel request FIFOs and
// merges per-channel completions into one completion FIFO through a round-robin arbiter.
module ctrl_dispatch_nch #(
    parameter int unsigned ADDRW       = 24,
    parameter int unsigned OPCODEW     = 2,
    parameter int unsigned NCH         = 4,
    parameter int unsigned REQ_QDEPTH  = 4,
    parameter int unsigned COMP_QDEPTH = 4,
    localparam int unsigned CHW        = (NCH > 1) ? $clog2(NCH) : 1,
    localparam int unsigned INSTRW     = 3 * ADDRW
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [OPCODEW-1:0]     in_opcode,
    input  logic [ADDRW-1:0]       in_key_addr,
    input  logic [ADDRW-1:0]       in_text_addr,
    input  logic [ADDRW-1:0]       in_dest_addr,
    output logic [NCH-1:0]         ch_valid,
    input  logic [NCH-1:0]         ch_ready,
    output logic [NCH*INSTRW-1:0]  ch_instr,
    input  logic [NCH-1:0]         cmp_valid,
    output logic [NCH-1:0]         cmp_ready,
    input  logic [NCH*ADDRW-1:0]   cmp_addr,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [ADDRW-1:0]       out_addr,
    output logic [CHW-1:0]         out_ch,
    output logic [7:0]             drop_cnt
);

    localparam int unsigned RPW = $clog2(REQ_QDEPTH);
    localparam int unsigned RCW = $clog2(REQ_QDEPTH + 1);
    localparam int unsigned CPW = $clog2(COMP_QDEPTH);
    localparam int unsigned CCW = $clog2(COMP_QDEPTH + 1);
    localparam int unsigned CEW = ADDRW + CHW;

    // ------------------------------------------------------------------
    // Dispatch and per-channel request FIFOs
    // ------------------------------------------------------------------
    logic [INSTRW-1:0] r_req_mem  [NCH][REQ_QDEPTH];
    logic [RPW-1:0]    r_req_wptr [NCH];
    logic [RPW-1:0]    r_req_rptr [NCH];
    logic [RCW-1:0]    r_req_cnt  [NCH];

    logic [NCH-1:0]    w_sel;
    logic [NCH-1:0]    w_req_full;
    logic [NCH-1:0]    w_req_empty;
    logic [NCH-1:0]    w_req_push;
    logic [NCH-1:0]    w_req_pop;
    logic              w_illegal;
    logic              w_accept;
    logic [7:0]        r_drop_cnt;

    always_comb begin
        w_sel       = '0;
        w_req_full  = '0;
        w_req_empty = '0;
        for (int i = 0; i < NCH; i++) begin
            w_sel[i]       = (32'(in_opcode) == 32'(i));
            w_req_full[i]  = (r_req_cnt[i] == RCW'(REQ_QDEPTH));
            w_req_empty[i] = (r_req_cnt[i] == '0);
        end
        // An opcode with no matching channel selects nothing, so it is always ready.
        w_illegal  = ~|w_sel;
        in_ready   = ~|(w_sel & w_req_full);
        w_accept   = in_valid && in_ready;
        w_req_push = w_accept ? w_sel : '0;
        w_req_pop  = ch_ready & ~w_req_empty;
    end

    always_comb begin
        ch_valid = ~w_req_empty;
        ch_instr = '0;
        for (int i = 0; i < NCH; i++) begin
            if (!w_req_empty[i]) begin
                ch_instr[i*INSTRW +: INSTRW] = r_req_mem[i][r_req_rptr[i]];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NCH; i++) begin
                r_req_wptr[i] <= '0;
                r_req_rptr[i] <= '0;
                r_req_cnt[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (w_req_push[i]) r_req_wptr[i] <= r_req_wptr[i] + RPW'(1);
                if (w_req_pop[i])  r_req_rptr[i] <= r_req_rptr[i] + RPW'(1);
                if (w_req_push[i] && !w_req_pop[i]) begin
                    r_req_cnt[i] <= r_req_cnt[i] + RCW'(1);
                end else if (!w_req_push[i] && w_req_pop[i]) begin
                    r_req_cnt[i] <= r_req_cnt[i] - RCW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NCH; i++) begin
            if (w_req_push[i]) begin
                r_req_mem[i][r_req_wptr[i]] <= {in_key_addr, in_text_addr, in_dest_addr};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_drop_cnt <= '0;
        end else if (w_accept && w_illegal && (r_drop_cnt != 8'hFF)) begin
            r_drop_cnt <= r_drop_cnt + 8'd1;
        end
    end

    assign drop_cnt = r_drop_cnt;

    // ------------------------------------------------------------------
    // Round-robin completion arbiter
    // ------------------------------------------------------------------
    logic [CHW-1:0]  r_rr_ptr;
    logic            w_gnt_found;
    logic [CHW-1:0]  w_gnt;
    logic            w_cmp_full;
    logic            w_cmp_empty;
    logic            w_cmp_push;
    logic            w_cmp_pop;
    logic [CEW-1:0]  w_cmp_din;

    always_comb begin
        int unsigned idx;
        idx         = 0;
        w_gnt_found = 1'b0;
        w_gnt       = '0;
        for (int unsigned k = 0; k < NCH; k++) begin
            idx = (32'(r_rr_ptr) + k) % NCH;
            if (!w_gnt_found && cmp_valid[idx]) begin
                w_gnt_found = 1'b1;
                w_gnt       = CHW'(idx);
            end
        end
    end

    always_comb begin
        w_cmp_push = w_gnt_found && !w_cmp_full;
        cmp_ready  = '0;
        if (w_cmp_push) cmp_ready[w_gnt] = 1'b1;
        w_cmp_din  = {cmp_addr[32'(w_gnt)*ADDRW +: ADDRW], w_gnt};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr_ptr <= '0;
        end else if (w_cmp_push) begin
            r_rr_ptr <= (w_gnt == CHW'(NCH - 1)) ? '0 : w_gnt + CHW'(1);
        end
    end

    // ------------------------------------------------------------------
    // Completion FIFO
    // ------------------------------------------------------------------
    logic [CEW-1:0] r_cmp_mem [COMP_QDEPTH];
    logic [CPW-1:0] r_cmp_wptr;
    logic [CPW-1:0] r_cmp_rptr;
    logic [CCW-1:0] r_cmp_cnt;

    always_comb begin
        w_cmp_full  = (r_cmp_cnt == CCW'(COMP_QDEPTH));
        w_cmp_empty = (r_cmp_cnt == '0);
        w_cmp_pop   = out_ready && !w_cmp_empty;
        out_valid   = !w_cmp_empty;
        out_addr    = '0;
        out_ch      = '0;
        if (!w_cmp_empty) begin
            {out_addr, out_ch} = r_cmp_mem[r_cmp_rptr];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cmp_wptr <= '0;
            r_cmp_rptr <= '0;
            r_cmp_cnt  <= '0;
        end else begin
            if (w_cmp_push) r_cmp_wptr <= r_cmp_wptr + CPW'(1);
            if (w_cmp_pop)  r_cmp_rptr <= r_cmp_rptr + CPW'(1);
            if (w_cmp_push && !w_cmp_pop) begin
                r_cmp_cnt <= r_cmp_cnt + CCW'(1);
            end else if (!w_cmp_push && w_cmp_pop) begin
                r_cmp_cnt <= r_cmp_cnt - CCW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_cmp_push) r_cmp_mem[r_cmp_wptr] <= w_cmp_din;
    end

endmodule

// File: tb/tb_ctrl_dispatch_nch.sv
// Randomized and directed bench for ctrl_dispatch_nch against a queue-based reference model;
// a second NCH=3 instance covers illegal-opcode drops and counter saturation.
module tb_ctrl_dispatch_nch;

    localparam int AW = 24;
    localparam int IW = 3 * AW;
    localparam int N  = 4;
    localparam int QD = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // NCH=4 instance
    logic            t_in_valid;
    logic            in_ready;
    logic [1:0]      t_in_opcode;
    logic [AW-1:0]   t_key, t_text, t_dest;
    logic [N-1:0]    ch_valid;
    logic [N-1:0]    t_ch_ready;
    logic [N*IW-1:0] ch_instr;
    logic [N-1:0]    t_cmp_valid;
    logic [N-1:0]    cmp_ready;
    logic [N*AW-1:0] t_cmp_addr;
    logic            out_valid;
    logic            t_out_ready;
    logic [AW-1:0]   out_addr;
    logic [1:0]      out_ch;
    logic [7:0]      drop_cnt;

    ctrl_dispatch_nch #(.ADDRW(AW), .OPCODEW(2), .NCH(N), .REQ_QDEPTH(QD), .COMP_QDEPTH(QD)) u_dut4 (
        .clk(clk), .rst(rst),
        .in_valid(t_in_valid), .in_ready(in_ready), .in_opcode(t_in_opcode),
        .in_key_addr(t_key), .in_text_addr(t_text), .in_dest_addr(t_dest),
        .ch_valid(ch_valid), .ch_ready(t_ch_ready), .ch_instr(ch_instr),
        .cmp_valid(t_cmp_valid), .cmp_ready(cmp_ready), .cmp_addr(t_cmp_addr),
        .out_valid(out_valid), .out_ready(t_out_ready), .out_addr(out_addr), .out_ch(out_ch),
        .drop_cnt(drop_cnt)
    );

    // NCH=3 instance
    logic            d3_in_valid;
    logic            d3_in_ready;
    logic [1:0]      d3_opcode;
    logic [2:0]      d3_ch_valid;
    logic [2:0]      d3_ch_ready;
    logic [3*IW-1:0] d3_ch_instr;
    logic [2:0]      d3_cmp_valid;
    logic [2:0]      d3_cmp_ready;
    logic [3*AW-1:0] d3_cmp_addr;
    logic            d3_out_valid;
    logic            d3_out_ready;
    logic [AW-1:0]   d3_out_addr;
    logic [1:0]      d3_out_ch;
    logic [7:0]      d3_drop_cnt;

    ctrl_dispatch_nch #(.ADDRW(AW), .OPCODEW(2), .NCH(3), .REQ_QDEPTH(QD), .COMP_QDEPTH(QD)) u_dut3 (
        .clk(clk), .rst(rst),
        .in_valid(d3_in_valid), .in_ready(d3_in_ready), .in_opcode(d3_opcode),
        .in_key_addr(24'h000111), .in_text_addr(24'h000222), .in_dest_addr(24'h000333),
        .ch_valid(d3_ch_valid), .ch_ready(d3_ch_ready), .ch_instr(d3_ch_instr),
        .cmp_valid(d3_cmp_valid), .cmp_ready(d3_cmp_ready), .cmp_addr(d3_cmp_addr),
        .out_valid(d3_out_valid), .out_ready(d3_out_ready), .out_addr(d3_out_addr),
        .out_ch(d3_out_ch), .drop_cnt(d3_drop_cnt)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: plain queues, a pointer and a counter
    logic [IW-1:0]   m_req [N][$];
    logic [AW+1:0]   m_cmp [$];
    int              m_rr;
    int              g_log [$];
    int              pop_log [$];
    int              acc_cnt;

    function automatic int model_grant();
        if (m_cmp.size() >= QD) return -1;
        for (int k = 0; k < N; k++) begin
            if (t_cmp_valid[(m_rr + k) % N]) return (m_rr + k) % N;
        end
        return -1;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < N; i++) m_req[i].delete();
        m_cmp.delete();
        m_rr = 0;
    endtask

    task automatic set_idle();
        t_in_valid  = 1'b0;
        t_in_opcode = '0;
        t_key       = '0;
        t_text      = '0;
        t_dest      = '0;
        t_ch_ready  = '0;
        t_cmp_valid = '0;
        t_cmp_addr  = '0;
        t_out_ready = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        set_idle();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_clear();
    endtask

    // Called at a negedge with inputs applied; checks, then advances one clock.
    task automatic step();
        int            g;
        logic          exp_rdy;
        logic [N-1:0]  exp_chv;
        logic [N-1:0]  exp_cr;
        logic [IW-1:0] exp_instr;
        logic [AW+1:0] head;
        #1;
        exp_rdy = (m_req[t_in_opcode].size() < QD);
        check_eq("in_ready", in_ready, exp_rdy);
        for (int i = 0; i < N; i++) begin
            exp_chv[i] = (m_req[i].size() != 0);
            exp_instr  = exp_chv[i] ? m_req[i][0] : '0;
            check_eq($sformatf("ch_instr%0d", i), ch_instr[i*IW +: IW], exp_instr);
        end
        check_eq("ch_valid", ch_valid, exp_chv);
        g      = model_grant();
        exp_cr = (g >= 0) ? N'(1 << g) : '0;
        check_eq("cmp_ready", cmp_ready, exp_cr);
        head = (m_cmp.size() != 0) ? m_cmp[0] : '0;
        check_eq("out_valid", out_valid, m_cmp.size() != 0);
        check_eq("out_addr", out_addr, head[AW+1:2]);
        check_eq("out_ch", out_ch, head[1:0]);
        check_eq("drop_cnt", drop_cnt, 8'd0);
        for (int i = 0; i < N; i++) if (cmp_ready[i]) g_log.push_back(i);
        if (out_valid && t_out_ready) pop_log.push_back(int'(out_ch));
        if (t_in_valid && in_ready) acc_cnt++;
        @(posedge clk);
        for (int i = 0; i < N; i++) begin
            if (t_ch_ready[i] && m_req[i].size() != 0) void'(m_req[i].pop_front());
        end
        if (t_in_valid && exp_rdy) m_req[t_in_opcode].push_back({t_key, t_text, t_dest});
        if (t_out_ready && m_cmp.size() != 0) void'(m_cmp.pop_front());
        if (g >= 0) begin
            m_cmp.push_back({t_cmp_addr[g*AW +: AW], 2'(g)});
            m_rr = (g + 1) % N;
        end
        @(negedge clk);
    endtask

    int exp_seq [5];

    initial begin
        rst          = 1'b1;
        d3_in_valid  = 1'b0;
        d3_opcode    = '0;
        d3_ch_ready  = '0;
        d3_cmp_valid = '0;
        d3_cmp_addr  = '0;
        d3_out_ready = 1'b0;
        acc_cnt      = 0;
        do_reset();

        // Reset state of the NCH=3 instance
        d3_opcode = 2'd3;
        #1;
        check_eq("d3_rst_rdy", d3_in_ready, 1'b1);
        check_eq("d3_rst_chv", d3_ch_valid, 3'b000);
        check_eq("d3_rst_instr", d3_ch_instr, '0);
        check_eq("d3_rst_cr", d3_cmp_ready, 3'b000);
        check_eq("d3_rst_ov", d3_out_valid, 1'b0);
        check_eq("d3_rst_oa", d3_out_addr, '0);
        check_eq("d3_rst_och", d3_out_ch, '0);
        check_eq("d3_rst_drop", d3_drop_cnt, 8'd0);

        // Illegal opcode on NCH=3: 300 drops, counter saturates at 255
        @(negedge clk);
        d3_in_valid = 1'b1;
        for (int i = 0; i < 300; i++) begin
            #1;
            if (i == 100) check_eq("d3_drop100", d3_drop_cnt, 8'd100);
            if (i % 60 == 0) begin
                check_eq("d3_ill_rdy", d3_in_ready, 1'b1);
                check_eq("d3_ill_chv", d3_ch_valid, 3'b000);
            end
            @(negedge clk);
        end
        d3_in_valid = 1'b0;
        #1;
        check_eq("d3_drop_sat", d3_drop_cnt, 8'd255);
        check_eq("d3_chv_none", d3_ch_valid, 3'b000);
        @(negedge clk);
        d3_in_valid = 1'b1;
        d3_opcode   = 2'd0;
        @(negedge clk);
        d3_in_valid = 1'b0;
        #1;
        check_eq("d3_legal_chv", d3_ch_valid, 3'b001);
        check_eq("d3_legal_instr", d3_ch_instr[IW-1:0], {24'h000111, 24'h000222, 24'h000333});
        check_eq("d3_drop_hold", d3_drop_cnt, 8'd255);
        @(negedge clk);

        // Idle after reset: every opcode ready
        do_reset();
        for (int op = 0; op < 4; op++) begin
            t_in_opcode = 2'(op);
            step();
        end

        // Single push on channel 2 and pop
        t_in_valid = 1'b1; t_in_opcode = 2'd2;
        t_key = 24'h000010; t_text = 24'h000020; t_dest = 24'h000030;
        step();
        t_in_valid = 1'b0;
        #1;
        check_eq("push_chv", ch_valid, 4'b0100);
        check_eq("push_instr", ch_instr[2*IW +: IW], 72'h000010_000020_000030);
        t_ch_ready = 4'b0100;
        step();
        t_ch_ready = '0;
        step();

        // Fill channel 1, backpressure, single pop, ordered drain across wrap
        acc_cnt = 0;
        t_in_valid = 1'b1; t_in_opcode = 2'd1;
        for (int i = 0; i < 5; i++) begin
            t_key = 24'(i); t_text = 24'(i + 16); t_dest = 24'(i + 1);
            step();
        end
        check_eq("fill_acc", acc_cnt, 4);
        t_ch_ready = 4'b0010;
        step();
        check_eq("full_nopass", acc_cnt, 4);
        t_ch_ready = '0;
        step();
        check_eq("refill_acc", acc_cnt, 5);
        t_in_valid = 1'b0;
        t_ch_ready = 4'b0010;
        for (int i = 0; i < 5; i++) step();
        t_ch_ready = '0;

        // Round robin with all requesters and a draining serializer
        do_reset();
        g_log.delete();
        pop_log.delete();
        t_cmp_addr  = {24'hA3, 24'hA2, 24'hA1, 24'hA0};
        t_cmp_valid = 4'hF;
        t_out_ready = 1'b1;
        for (int i = 0; i < 5; i++) step();
        t_cmp_valid = '0;
        for (int i = 0; i < 6; i++) step();
        exp_seq = '{0, 1, 2, 3, 0};
        check_eq("rr_gnt_n", g_log.size(), 5);
        check_eq("rr_pop_n", pop_log.size(), 5);
        for (int i = 0; i < 5; i++) begin
            if (i < g_log.size())   check_eq($sformatf("rr_gnt%0d", i), g_log[i], exp_seq[i]);
            if (i < pop_log.size()) check_eq($sformatf("rr_och%0d", i), pop_log[i], exp_seq[i]);
        end

        // Completion FIFO full, then one out_ready pulse
        g_log.delete();
        t_cmp_valid = 4'hF;
        t_out_ready = 1'b0;
        for (int i = 0; i < 6; i++) step();
        #1;
        check_eq("cfull_cr", cmp_ready, 4'b0000);
        t_out_ready = 1'b1;
        step();
        t_out_ready = 1'b0;
        for (int i = 0; i < 3; i++) step();
        exp_seq = '{1, 2, 3, 0, 1};
        check_eq("cfull_gnt_n", g_log.size(), 5);
        for (int i = 0; i < 5; i++) begin
            if (i < g_log.size()) check_eq($sformatf("cfull_gnt%0d", i), g_log[i], exp_seq[i]);
        end

        // Randomized traffic with a reset mid-run
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            if (i == 700) do_reset();
            t_in_valid  = ($urandom_range(0, 3) != 0);
            t_in_opcode = 2'($urandom_range(0, 3));
            t_key       = 24'($urandom);
            t_text      = 24'($urandom);
            t_dest      = 24'($urandom);
            t_ch_ready  = 4'($urandom) & 4'($urandom);
            t_cmp_valid = 4'($urandom);
            t_cmp_addr  = {24'($urandom), 24'($urandom), 24'($urandom), 24'($urandom)};
            t_out_ready = ($urandom_range(0, 2) != 0);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/ctrl_dispatch_nch.md
Name: ctrl_dispatch_nch

Overview:
- Parametrised N-channel control core; successor to the fixed AES/SHA two-channel control path.
- Takes decoded instructions from the deserializer and routes them by opcode into per-channel request FIFOs, which feed the accelerator FSMs.
- Merges per-channel completion addresses into one completion FIFO through a round-robin arbiter; the FIFO feeds the serializer.
- Illegal opcodes are dropped and counted.

Parameters:
- ADDRW, 24, address width.
- OPCODEW, 2, opcode width; must be >= CHW.
- NCH, 4, number of accelerator channels (2..8).
- REQ_QDEPTH, 4, entries per channel request FIFO (power of 2, >= 2).
- COMP_QDEPTH, 4, entries in the completion FIFO (power of 2, >= 2).
- Derived: CHW = max(1, $clog2(NCH)); INSTRW = 3*ADDRW.

Ports:
- clk, input, 1, single clock; all logic is on its rising edge.
- rst, input, 1, synchronous, active-high reset.
- in_valid, input, 1, instruction valid from deserializer.
- in_ready, output, 1, instruction accepted when in_valid && in_ready.
- in_opcode, input, OPCODEW, channel select.
- in_key_addr, input, ADDRW, key address.
- in_text_addr, input, ADDRW, text address.
- in_dest_addr, input, ADDRW, destination address.
- ch_valid, output, NCH, per-channel request FIFO non-empty.
- ch_ready, input, NCH, per-channel FSM pops the head.
- ch_instr, output, NCH*INSTRW, per-channel head entry {key,text,dest}; channel i occupies bits [i*INSTRW +: INSTRW].
- cmp_valid, input, NCH, per-channel completion valid.
- cmp_ready, output, NCH, per-channel completion accepted.
- cmp_addr, input, NCH*ADDRW, per-channel completion dest address.
- out_valid, output, 1, completion FIFO non-empty.
- out_ready, input, 1, serializer pops the head.
- out_addr, output, ADDRW, head completion address.
- out_ch, output, CHW, channel index of the head completion.
- drop_cnt, output, 8, saturating count of illegal-opcode drops.

Behaviour:
- Reset (rst high at an edge): all FIFOs empty, rr_ptr=0, drop_cnt=0.
  - ch_valid=0, cmp_ready=0, out_valid=0.
  - out_addr, out_ch and ch_instr read 0.
  - Reset mid-operation discards every queued entry; no partial state survives.
- Dispatch:
  - ch = in_opcode.
  - If ch < NCH: in_ready = !full[ch] (combinational).
  - If ch >= NCH: in_ready = 1. On accept the entry is dropped and drop_cnt increments, saturating at 255.
  - An accepted legal entry is pushed into FIFO[ch] and is visible on ch_valid/ch_instr the next cycle (1-cycle latency).
- Request FIFOs:
  - First-word fall-through; ch_valid[i] = !empty[i].
  - A pop occurs on ch_valid[i] && ch_ready[i].
  - A full FIFO holds in_ready low even if a pop occurs in the same cycle (no pass-through).
  - Push and pop in the same cycle on a non-full, non-empty FIFO leave the count unchanged.
  - Pointers wrap modulo REQ_QDEPTH; the count is $clog2(depth+1) bits.
- Completion arbiter:
  - Scans cmp_valid from rr_ptr upward (mod NCH) and grants the first asserted channel g.
  - cmp_ready = one-hot(g) when a requester exists and the completion FIFO is not full; otherwise 0.
  - At most one completion is accepted per cycle.
  - On accept: push {cmp_addr[g], g} and set rr_ptr = (g+1) mod NCH.
  - With no accept, rr_ptr holds.
  - A requester holding cmp_valid is served within NCH accepts.
- Completion FIFO:
  - FWFT; out_valid = !empty; pop on out_valid && out_ready.
  - A full FIFO blocks push even with a simultaneous pop.
  - Push-to-out_valid latency is 1 cycle.
- No combinational path from ch_ready or out_ready to any output.

Test Plan:
- Reset then idle -> all outputs 0 and in_ready=1 for every opcode while FIFOs are empty.
- NCH=4. Push opcode 2 with key=0x000010, text=0x000020, dest=0x000030 -> next cycle ch_valid=4'b0100 and ch_instr[2] = {0x000010, 0x000020, 0x000030}. Pop with ch_ready[2] -> ch_valid=0.
- ch_ready=0; push 5 instructions with opcode 1 -> in_ready drops after the 4th accept. One pop then re-enables in_ready. FIFO order is preserved, including across wrap-around.
- NCH=3, OPCODEW=2; push opcode 3 repeatedly 300 times -> no ch_valid, drop_cnt saturates at 255.
- cmp_valid=4'b1111 held with addrs 0xA0..0xA3 and out_ready=1 -> completions accepted in channel order 0,1,2,3,0 with out_ch matching.
- out_ready=0 with continuous cmp_valid -> 4 accepts, then cmp_ready=0. A single out_ready pulse gives exactly one further accept, at the next round-robin channel.
